// File: rtl/tdm_demux2_pkg.sv
// tdm_pkg: shared FSM state type and frame sizing helpers (frame grows by a parity slot under TDM_DEMUX_PARITY_EN)
package tdm_pkg;
  typedef enum logic {HUNT, LOCKED} tdm_state_t;
  function automatic int frame_len(input int nch);
`ifdef TDM_DEMUX_PARITY_EN
    return nch + 1;
`else
    return nch;
`endif
  endfunction
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_demux2_slot_counter.sv
// tdm_slot_counter: mod-FRAME_LEN slot counter with clear / load-1 / advance controls
module tdm_slot_counter #(
  parameter int NCH = 2,
  parameter int FRAME_LEN = 2,
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load1,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             at_last_data,
  output logic             at_zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (load1) count <= CNT_W'(1);
    else if (advance) count <= (count == CNT_W'(FRAME_LEN - 1)) ? '0 : count + 1'b1;
  assign at_last_data = count == CNT_W'(NCH - 1);
  assign at_zero = count == '0;
endmodule

// File: rtl/tdm_demux2.sv
// tdm_demux2: TDM receive endpoint with HUNT/LOCKED frame alignment; TDM_DEMUX_PARITY_EN adds an even-parity slot per frame
module tdm_demux2 import tdm_pkg::*; #(
  parameter int NCH = 2,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   line_d,
  input  logic           line_sync,
  output logic [NCH*W-1:0] out_d,
  output logic           frame_valid,
  output logic           locked,
  output logic           sync_err,
  output logic           parity_err
);
  localparam int FRAME_LEN = frame_len(NCH);
  localparam int CNT_W = cnt_w(FRAME_LEN);
  tdm_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [NCH*W-1:0] shadow;
  logic at_last, at_zero, clr, ld1, adv, wr, done, serr_nxt;
`ifdef TDM_DEMUX_PARITY_EN
  logic par_slot, par_bad, perr_nxt;
  assign par_slot = cnt == CNT_W'(NCH);
  assign par_bad = ^shadow ^ line_d[0];
`endif
  tdm_slot_counter #(.NCH(NCH), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clear(clr), .load1(ld1), .advance(adv),
    .count(cnt), .at_last_data(at_last), .at_zero(at_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  // realign on a misplaced sync outranks frame completion
  always_comb begin
    state_nxt = state;
    clr = 1'b0;
    ld1 = 1'b0;
    adv = 1'b0;
    wr = 1'b0;
    done = 1'b0;
    serr_nxt = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_nxt = 1'b0;
`endif
    if (state == HUNT) begin
      ld1 = line_sync;
      state_nxt = line_sync ? LOCKED : HUNT;
    end else if (at_zero && !line_sync) begin
      serr_nxt = 1'b1;
      clr = 1'b1;
      state_nxt = HUNT;
    end else if (!at_zero && line_sync) begin
      serr_nxt = 1'b1;
      ld1 = 1'b1;
    end else begin
      adv = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
      wr = !par_slot;
      done = par_slot && !par_bad;
      perr_nxt = par_slot && par_bad;
`else
      wr = 1'b1;
      done = at_last;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      out_d <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      frame_valid <= done;
      sync_err <= serr_nxt;
      if (ld1) shadow[W-1:0] <= line_d;
      else if (wr) for (int k = 0; k < NCH; k++) if (cnt == CNT_W'(k)) shadow[k*W +: W] <= line_d;
`ifdef TDM_DEMUX_PARITY_EN
      if (done) out_d <= shadow;
`else
      if (done) out_d <= {line_d, shadow[(NCH-1)*W-1:0]};
`endif
    end
`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_err <= 1'b0;
    else parity_err <= perr_nxt;
`else
  assign parity_err = 1'b0;
`endif
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: directed checks of tdm_demux2 at NCH=2/W=1 and NCH=4/W=8
module tb_tdm_demux2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [0:0] d2 = '0;
  logic s2 = 1'b0;
  logic [7:0] d4 = '0;
  logic s4 = 1'b0;
  logic [1:0] o2;
  logic [31:0] o4;
  logic fv2, lk2, se2, pe2, fv4, lk4, se4, pe4;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux2 #(.NCH(2), .W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .line_d(d2), .line_sync(s2), .out_d(o2),
    .frame_valid(fv2), .locked(lk2), .sync_err(se2), .parity_err(pe2)
  );
  tdm_demux2 #(.NCH(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .line_d(d4), .line_sync(s4), .out_d(o4),
    .frame_valid(fv4), .locked(lk4), .sync_err(se4), .parity_err(pe4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic slot2(input logic d, input logic s);
    d2 = d;
    s2 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic slot4(input logic [7:0] d, input logic s);
    d4 = d;
    s4 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input string tag, input logic [31:0] w);
    slot4(w[7:0], 1'b1);
    chk({tag, "_fv_lo"}, 64'(fv4), 64'd0);
    slot4(w[15:8], 1'b0);
    slot4(w[23:16], 1'b0);
    slot4(w[31:24], 1'b0);
    chk({tag, "_fv"}, 64'(fv4), 64'd1);
    chk({tag, "_out"}, 64'(o4), 64'(w));
    chk({tag, "_serr"}, 64'(se4), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    d2 = 1'b1;
    s2 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out", 64'(o2), 64'd0);
    chk("rst_fv", 64'(fv2), 64'd0);
    chk("rst_lock", 64'(lk2), 64'd0);
    chk("rst_serr", 64'(se2), 64'd0);
    chk("rst_perr", 64'(pe2), 64'd0);
    s2 = 1'b0;
    rst_n = 1'b1;
`ifndef TDM_DEMUX_PARITY_EN
    slot2(1'b1, 1'b1);
    chk("n2_lock", 64'(lk2), 64'd1);
    chk("n2_fv_early", 64'(fv2), 64'd0);
    slot2(1'b0, 1'b0);
    chk("n2_fv", 64'(fv2), 64'd1);
    chk("n2_out", 64'(o2), 64'h1);
    chk("n2_perr", 64'(pe2), 64'd0);
    slot2(1'b1, 1'b0);
    chk("n2_miss_serr", 64'(se2), 64'd1);
    chk("n2_miss_lock", 64'(lk2), 64'd0);
    chk("n2_miss_out", 64'(o2), 64'h1);
    chk("n2_miss_fv", 64'(fv2), 64'd0);
    slot2(1'b0, 1'b1);
    chk("n2_relock_serr", 64'(se2), 64'd0);
    slot2(1'b1, 1'b1);
    chk("n2_mis_serr", 64'(se2), 64'd1);
    chk("n2_mis_fv", 64'(fv2), 64'd0);
    chk("n2_mis_lock", 64'(lk2), 64'd1);
    slot2(1'b1, 1'b0);
    chk("n2_realign_fv", 64'(fv2), 64'd1);
    chk("n2_realign_out", 64'(o2), 64'h3);
    slot2(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out", 64'(o2), 64'd0);
    chk("arst_lock", 64'(lk2), 64'd0);
    #2;
    rst_n = 1'b1;
    slot2(1'b1, 1'b0);
    chk("post_hunt_fv", 64'(fv2), 64'd0);
    chk("post_hunt_lock", 64'(lk2), 64'd0);
    slot2(1'b0, 1'b1);
    chk("post_sync_fv", 64'(fv2), 64'd0);
    chk("post_sync_out", 64'(o2), 64'd0);
    slot2(1'b1, 1'b0);
    chk("post_fv", 64'(fv2), 64'd1);
    chk("post_out", 64'(o2), 64'h2);
    slot2(1'b0, 1'b0);
    chk("n4_idle_lock", 64'(lk4), 64'd0);
    frame4("f1", 32'h44332211);
    frame4("f2", 32'h88776655);
    frame4("f3", 32'hCCBBAA99);
    slot4(8'hDD, 1'b0);
    chk("n4_miss_serr", 64'(se4), 64'd1);
    chk("n4_miss_lock", 64'(lk4), 64'd0);
    chk("n4_miss_out", 64'(o4), 64'hCCBBAA99);
    slot4(8'h00, 1'b0);
    chk("n4_serr_pulse", 64'(se4), 64'd0);
    frame4("f4", 32'h04030201);
    slot4(8'h10, 1'b1);
    slot4(8'h20, 1'b0);
    slot4(8'h30, 1'b1);
    chk("n4_mis_serr", 64'(se4), 64'd1);
    chk("n4_mis_lock", 64'(lk4), 64'd1);
    slot4(8'h40, 1'b0);
    chk("n4_mis_fv", 64'(fv4), 64'd0);
    slot4(8'h50, 1'b0);
    chk("n4_mis_fv2", 64'(fv4), 64'd0);
    slot4(8'h60, 1'b0);
    chk("n4_realign_fv", 64'(fv4), 64'd1);
    chk("n4_realign_out", 64'(o4), 64'h60504030);
    chk("n4_realign_serr", 64'(se4), 64'd0);
`else
    slot2(1'b1, 1'b1);
    slot2(1'b0, 1'b0);
    chk("p_fv_early", 64'(fv2), 64'd0);
    slot2(1'b1, 1'b0);
    chk("p_ok_fv", 64'(fv2), 64'd1);
    chk("p_ok_out", 64'(o2), 64'h1);
    chk("p_ok_perr", 64'(pe2), 64'd0);
    slot2(1'b0, 1'b1);
    slot2(1'b1, 1'b0);
    slot2(1'b0, 1'b0);
    chk("p_bad_perr", 64'(pe2), 64'd1);
    chk("p_bad_fv", 64'(fv2), 64'd0);
    chk("p_bad_out", 64'(o2), 64'h1);
    chk("p_bad_lock", 64'(lk2), 64'd1);
    slot2(1'b1, 1'b1);
    chk("p_perr_pulse", 64'(pe2), 64'd0);
    chk("p_keep_serr", 64'(se2), 64'd0);
    slot2(1'b1, 1'b0);
    slot2(1'b0, 1'b0);
    chk("p_ok2_fv", 64'(fv2), 64'd1);
    chk("p_ok2_out", 64'(o2), 64'h3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receive-side endpoint of the time-division link whose transmit side is the 2->1 select path.
- Takes one shared serial data line plus a slot-0 sync marker and routes each slot back to its own registered channel output.
- Per-channel frame is presented in parallel with a one-cycle valid strobe.
- Tracks frame alignment with a HUNT/LOCKED state machine and flags sync faults.

Parameters:
- NCH, 2, number of channels (slots per frame), legal range 2..16.
- W, 1, bits carried per slot.

Ports:
- clk  input  1  single clock; all sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- line_d  input  W  shared data line, one slot per clk cycle.
- line_sync  input  1  high during slot 0 of each frame.
- out_d  output  NCH*W  registered channel data; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse; out_d updated this cycle.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on a sync fault.
- parity_err  output  1  one-cycle pulse on a parity fault; tied 0 without the optional feature.

Behaviour:
- Reset is asynchronous, active-low, and used only as stated: while rst_n=0, all outputs = 0, state = HUNT, slot counter = 0, shadow register = 0.
- Slot counter width is $clog2(FRAME_LEN). FRAME_LEN = NCH, or NCH+1 with the optional feature.
- HUNT state:
  - line_d is ignored until line_sync=1.
  - On the edge sampling line_sync=1: slot 0 is captured into shadow[0], counter <= 1, state <= LOCKED.
- LOCKED state, each edge:
  - line_d is written into shadow[counter].
  - counter increments and wraps FRAME_LEN-1 -> 0.
- Frame completion:
  - On the edge sampling the last data slot (counter = NCH-1), out_d <= {line_d, shadow[NCH-2:0]} as a single atomic update.
  - frame_valid = 1 for the following cycle.
  - Latency: 1 clk from last slot sampled to out_d/frame_valid visible.
- out_d holds its value between frames. It never shows a partially assembled frame.
- Missing sync (counter = 0 and line_sync = 0):
  - sync_err pulses.
  - State <= HUNT, frame discarded, out_d unchanged.
- Misplaced sync (counter != 0 and line_sync = 1):
  - sync_err pulses.
  - Realign: the current slot is treated as slot 0, shadow[0] is captured, counter <= 1, state stays LOCKED.
  - The partial frame is discarded and no frame_valid is issued for it.
- Simultaneous events: sync at the last slot with NCH = 2 is a misplaced sync. Realign takes priority over frame completion, so no frame_valid.
- locked = (state == LOCKED), registered.
- Reset mid-frame: the partial frame is lost. After release, the block re-hunts and out_d stays 0 until the first complete frame.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - FRAME_LEN = NCH+1.
  - The extra final slot carries even parity: the XOR of all NCH*W data bits plus the parity slot's bit 0 must be 0; parity slot bits [W-1:1] are ignored.
  - On the parity-slot edge:
    - Match: out_d updates and frame_valid pulses.
    - Mismatch: out_d is held, parity_err pulses, and lock is kept.
  - Latency is measured from the parity slot, not the last data slot.
- Undefined: FRAME_LEN = NCH, parity_err is tied 0, and completion follows the rule above.

Decomposition:
- Package tdm_pkg holds:
  - typedef enum logic {HUNT, LOCKED} tdm_state_t.
  - Function frame_len(nch), which adds 1 under TDM_DEMUX_PARITY_EN.
  - Constant CNT_W derivation helper.
- Sub-module tdm_slot_counter provides the mod-FRAME_LEN counter:
  - Inputs: clear, load1, advance.
  - Outputs: count, at_last_data, at_zero.
- The top level holds the FSM, the shadow register, and the output register.

Test Plan:
- NCH=2, W=1: after reset release, send sync+line_d=1, then line_d=0 -> frame_valid pulses 1 cycle after slot 1 with out_d=2'b01, locked=1; all outputs 0 during reset.
- NCH=4, W=8: three consecutive frames A0..A3 = 11,22,33,44 then 55,66,77,88 then 99,AA,BB,CC -> frame_valid every 4 cycles, out_d=32'h44332211, then 32'h88776655, then 32'hCCBBAA99; no sync_err.
- NCH=4: drop sync at the start of frame 2 -> sync_err pulse, locked falls, out_d stays at frame-1 value; next sync relocks and the following full frame updates out_d.
- NCH=4: assert sync at slot 2 -> sync_err pulse, no frame_valid for the broken frame; the next 4 slots form a valid frame.
- NCH=2: assert rst_n=0 after slot 0 -> all outputs 0 immediately (async); after release, no frame_valid until a full synced frame.
- TDM_DEMUX_PARITY_EN, NCH=2, W=1: data 1,0 with parity bit 1 -> out_d=2'b01, frame_valid; parity bit 0 -> parity_err pulse, out_d held, locked stays 1.
